// File: rtl/layer_ctrl.sv
// Layer controller: streams weights into neurons, broadcasts inputs,
// and waits for every neuron to report its output.
module layer_ctrl #(
  parameter int layerNo   = 1,
  parameter int numNeuron = 30,
  parameter int numWeight = 784,
  parameter int dataWidth = 16,
  localparam int AW = (numWeight > 1) ? $clog2(numWeight) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [31:0]          w_data,
  input  logic                 w_valid,
  output logic                 w_ready,
  output logic                 weightValid,
  output logic [31:0]          weightValue,
  output logic [31:0]          cfg_layer_num,
  output logic [31:0]          cfg_neuron_num,
  input  logic                 start,
  output logic [AW-1:0]        in_addr,
  input  logic [dataWidth-1:0] in_data,
  output logic [dataWidth-1:0] neuron_in,
  output logic                 neuron_in_valid,
  input  logic [numNeuron-1:0] neuron_outvalid,
  output logic                 busy,
  output logic                 loaded,
  output logic                 done,
  output logic                 err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam int WW  = $clog2(numWeight + 1);
  localparam int NCW = $clog2(numNeuron + 1);

  localparam logic [WW-1:0]  W_LAST = WW'(numWeight - 1);
  localparam logic [NCW-1:0] N_LAST = NCW'(numNeuron - 1);
  localparam logic [AW-1:0]  A_LAST = AW'(numWeight - 1);

  logic [2:0]           state;
  logic [WW-1:0]        wcnt;
  logic [NCW-1:0]       ncnt;
  logic [numNeuron-1:0] mask;
  logic [numNeuron-1:0] mask_nxt;
  logic                 xfer;
  logic                 ov_err;

  assign w_ready       = (state == LOAD);
  assign xfer          = w_ready & w_valid;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign cfg_layer_num = 32'(layerNo);
  // Buffer data lands one cycle after the address, aligned with valid
  assign neuron_in     = neuron_in_valid ? in_data : '0;
  assign mask_nxt      = mask | neuron_outvalid;
  assign ov_err        = (state != WAIT) ? |neuron_outvalid
                                         : |(neuron_outvalid & mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      wcnt            <= '0;
      ncnt            <= '0;
      mask            <= '0;
      in_addr         <= '0;
      weightValid     <= 1'b0;
      weightValue     <= '0;
      cfg_neuron_num  <= '0;
      neuron_in_valid <= 1'b0;
      loaded          <= 1'b0;
      err             <= 1'b0;
    end else begin
      weightValid     <= xfer;
      neuron_in_valid <= (state == STREAM);
      if (ov_err)
        err <= 1'b1;
      if (xfer) begin
        weightValue    <= w_data;
        cfg_neuron_num <= 32'(ncnt);
      end
      unique case (state)
        IDLE: begin
          if (load_start) begin
            state  <= LOAD;
            loaded <= 1'b0;
            wcnt   <= '0;
            ncnt   <= '0;
          end else if (start) begin
            if (loaded)
              state <= STREAM;
            else
              err <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (wcnt == W_LAST) begin
              wcnt <= '0;
              ncnt <= ncnt + NCW'(1);
              if (ncnt == N_LAST) begin
                loaded <= 1'b1;
                state  <= IDLE;
              end
            end else begin
              wcnt <= wcnt + WW'(1);
            end
          end
        end
        STREAM: begin
          if (in_addr == A_LAST) begin
            in_addr <= '0;
            state   <= WAIT;
          end else begin
            in_addr <= in_addr + AW'(1);
          end
        end
        WAIT: begin
          mask <= mask_nxt;
          if (&mask_nxt)
            state <= DONE;
        end
        DONE: begin
          mask  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
